// File: rtl/rx_block_sync.sv
// 64b/66b receive gearbox: regroups the 32-bit transceiver stream into
// 66-bit blocks presented as header + first half, then second half.
module rx_block_sync #(
  parameter int DATA_WIDTH = 32,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_slip,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [HDR_WIDTH-1:0]  o_tx_sync_hdr,
  output logic                  o_tx_data_valid
);

  localparam int BUF_W  = 3 * DATA_WIDTH;
  localparam int WORK_W = BUF_W + DATA_WIDTH;
  localparam int CNT_W  = $clog2(WORK_W + 1);

  localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] A_BITS    = CNT_W'(HDR_WIDTH + DATA_WIDTH);
  localparam logic [CNT_W-1:0] ONE_BIT   = CNT_W'(1);
  localparam logic [CNT_W-1:0] NO_BITS   = CNT_W'(0);

  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_t;

  logic [BUF_W-1:0]      buf_r;
  logic [CNT_W-1:0]      fill_r;
  phase_t                phase_r;

  logic [WORK_W-1:0]     work_s;
  logic [CNT_W-1:0]      avail_s;
  logic [CNT_W-1:0]      used_s;
  logic [BUF_W-1:0]      next_buf_s;
  logic [CNT_W-1:0]      next_fill_s;
  phase_t                next_phase_s;
  logic                  emit_s;
  logic [DATA_WIDTH-1:0] data_s;
  logic [HDR_WIDTH-1:0]  hdr_s;

  // Merge the new word behind the unconsumed bits, apply slip, pick the beat.
  always_comb begin
    // Bits above fill_r in buf_r are always zero, so OR-merge is safe.
    work_s = {{DATA_WIDTH{1'b0}}, buf_r}
           | ({{BUF_W{1'b0}}, i_rx_data} << fill_r);
    avail_s = fill_r + WORD_BITS;
    if (i_slip) begin
      work_s  = work_s >> 1;
      avail_s = avail_s - ONE_BIT;
    end else begin
      work_s  = work_s;
      avail_s = avail_s;
    end

    emit_s       = 1'b0;
    used_s       = NO_BITS;
    next_phase_s = phase_r;
    data_s       = o_tx_data;
    hdr_s        = o_tx_sync_hdr;

    case (phase_r)
      PH_A: begin
        if (avail_s >= A_BITS) begin
          emit_s       = 1'b1;
          used_s       = A_BITS;
          hdr_s        = work_s[HDR_WIDTH-1:0];
          data_s       = work_s[HDR_WIDTH +: DATA_WIDTH];
          next_phase_s = PH_B;
        end else begin
          emit_s       = 1'b0;
        end
      end
      PH_B: begin
        if (avail_s >= WORD_BITS) begin
          emit_s       = 1'b1;
          used_s       = WORD_BITS;
          data_s       = work_s[DATA_WIDTH-1:0];
          next_phase_s = PH_A;
        end else begin
          emit_s       = 1'b0;
        end
      end
      default: begin
        emit_s       = 1'b0;
        next_phase_s = PH_A;
      end
    endcase

    next_buf_s  = BUF_W'(work_s >> used_s);
    next_fill_s = avail_s - used_s;
  end

  // Buffer, fill count, phase and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      buf_r           <= {BUF_W{1'b0}};
      fill_r          <= NO_BITS;
      phase_r         <= PH_A;
      o_tx_data       <= {DATA_WIDTH{1'b0}};
      o_tx_sync_hdr   <= {HDR_WIDTH{1'b0}};
      o_tx_data_valid <= 1'b0;
    end else begin
      buf_r           <= next_buf_s;
      fill_r          <= next_fill_s;
      phase_r         <= next_phase_s;
      o_tx_data       <= data_s;
      o_tx_sync_hdr   <= hdr_s;
      o_tx_data_valid <= emit_s;
    end
  end

endmodule

// File: tb/tb_rx_block_sync.sv
// Self-checking bench for rx_block_sync: bit-queue reference model feeding
// an expected-beat scoreboard, covering prime, steady stream, slips and reset.
module tb_rx_block_sync;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_rx_data;
  logic        i_slip;
  logic [31:0] o_tx_data;
  logic [1:0]  o_tx_sync_hdr;
  logic        o_tx_data_valid;

  rx_block_sync #(.DATA_WIDTH(32), .HDR_WIDTH(2)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_rx_data      (i_rx_data),
    .i_slip         (i_slip),
    .o_tx_data      (o_tx_data),
    .o_tx_sync_hdr  (o_tx_sync_hdr),
    .o_tx_data_valid(o_tx_data_valid)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        valid;
    logic        phase_a;
    logic [1:0]  hdr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  bit          src_q[$];
  bit          mdl_q[$];
  logic        mdl_phase_b;
  logic [1:0]  mdl_hdr;
  logic [31:0] mdl_data;
  int          n_cmp = 0;
  int          n_err = 0;
  int          valid_cnt = 0;
  bit          check_hdr_legal = 1'b1;
  exp_t        last_e;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic gen_block(input logic [1:0] hdr);
    logic [63:0] p;
    p = {$urandom(), $urandom()};
    src_q.push_back(hdr[0]);
    src_q.push_back(hdr[1]);
    for (int k = 0; k < 64; k++) src_q.push_back(p[k]);
  endtask

  task automatic model_reset();
    src_q.delete();
    mdl_q.delete();
    exp_q.delete();
    mdl_phase_b = 1'b0;
    mdl_hdr     = 2'b00;
    mdl_data    = 32'h0;
  endtask

  // Reference behaviour for one clock edge, pushed to the scoreboard.
  task automatic model_edge(input logic [31:0] word, input logic slip);
    exp_t e;
    for (int k = 0; k < 32; k++) mdl_q.push_back(word[k]);
    if (slip && mdl_q.size() > 0) void'(mdl_q.pop_front());
    e.valid   = 1'b0;
    e.phase_a = 1'b0;
    if (!mdl_phase_b && mdl_q.size() >= 34) begin
      for (int k = 0; k < 2; k++) mdl_hdr[k] = mdl_q.pop_front();
      for (int k = 0; k < 32; k++) mdl_data[k] = mdl_q.pop_front();
      mdl_phase_b = 1'b1;
      e.valid     = 1'b1;
      e.phase_a   = 1'b1;
    end else if (mdl_phase_b && mdl_q.size() >= 32) begin
      for (int k = 0; k < 32; k++) mdl_data[k] = mdl_q.pop_front();
      mdl_phase_b = 1'b0;
      e.valid     = 1'b1;
    end
    e.hdr  = mdl_hdr;
    e.data = mdl_data;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic slip);
    logic [31:0] w;
    exp_t e;
    while (src_q.size() < 32) gen_block(2'($urandom_range(1, 2)));
    for (int k = 0; k < 32; k++) w[k] = src_q.pop_front();
    i_rx_data = w;
    i_slip    = slip;
    model_edge(w, slip);
    @(posedge i_clk);
    #1;
    i_slip = 1'b0;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      last_e = e;
      check_val("valid", 64'(o_tx_data_valid), 64'(e.valid));
      check_val("hdr", 64'(o_tx_sync_hdr), 64'(e.hdr));
      check_val("data", 64'(o_tx_data), 64'(e.data));
      if (check_hdr_legal && e.valid && e.phase_a)
        check_val("hdr_legal", 64'(o_tx_sync_hdr == 2'b01 || o_tx_sync_hdr == 2'b10), 64'd1);
    end
    if (o_tx_data_valid) valid_cnt++;
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_data"}, 64'(o_tx_data), 64'd0);
    check_val({tag, "_hdr"}, 64'(o_tx_sync_hdr), 64'd0);
    check_val({tag, "_valid"}, 64'(o_tx_data_valid), 64'd0);
  endtask

  initial begin
    bit found;
    i_reset   = 1'b1;
    i_rx_data = 32'h0;
    i_slip    = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check_cleared("rst");
    @(negedge i_clk);
    i_reset = 1'b0;

    // Prime: first valid beat on the second sampled word.
    gen_block(2'b01);
    step(1'b0);
    check_val("prime_idle", 64'(o_tx_data_valid), 64'd0);
    step(1'b0);
    check_val("prime_valid", 64'(o_tx_data_valid), 64'd1);
    check_val("prime_hdr", 64'(o_tx_sync_hdr), 64'd1);

    // Steady stream, ~300 blocks, then a 33-edge window.
    repeat (620) step(1'b0);
    valid_cnt = 0;
    repeat (33) step(1'b0);
    check_val("win33", 64'(valid_cnt), 64'd32);

    // Single slip, then 65 more (mixed spacing) to complete a full block.
    check_hdr_legal = 1'b0;
    step(1'b1);
    repeat (40) step(1'b0);
    for (int i = 0; i < 65; i++) begin
      step(1'b1);
      repeat (i % 3) step(1'b0);
    end
    check_hdr_legal = 1'b1;
    repeat (200) step(1'b0);

    // Slip on an idle edge.
    check_hdr_legal = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      if (!mdl_phase_b && mdl_q.size() + 32 < 34) begin
        step(1'b1);
        found = 1'b1;
      end else begin
        step(1'b0);
      end
    end
    check_val("idle_slip_found", 64'(found), 64'd1);
    repeat (5) step(1'b0);

    // Slip on a phase-B edge.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mdl_phase_b) begin
        step(1'b1);
        found = 1'b1;
      end else begin
        step(1'b0);
      end
    end
    check_val("b_slip_found", 64'(found), 64'd1);
    repeat (64) step(1'b1);
    check_hdr_legal = 1'b1;
    repeat (100) step(1'b0);

    // Reset asserted while the DUT awaits a second half.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0);
      if (last_e.valid && last_e.phase_a) found = 1'b1;
    end
    check_val("b_reset_found", 64'(found), 64'd1);
    #2;
    i_reset = 1'b1;
    #1;
    check_cleared("async_rst");
    @(negedge i_clk);
    i_reset = 1'b0;
    model_reset();
    gen_block(2'b01);
    step(1'b0);
    check_val("rst_prime_idle", 64'(o_tx_data_valid), 64'd0);
    step(1'b0);
    check_val("rst_prime_valid", 64'(o_tx_data_valid), 64'd1);
    check_val("rst_prime_hdr", 64'(o_tx_sync_hdr), 64'd1);
    check_val("rst_prime_phase_a", 64'(last_e.phase_a), 64'd1);
    repeat (80) step(1'b0);

    check_val("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
